// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared encodings, frame constants and waveform mapping for wavegen_dac
package wavegen_pkg;
  typedef enum logic [1:0] {MODE_SAW, MODE_SQUARE, MODE_TRI, MODE_DC} mode_t;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  localparam int FRAME_BITS = 32;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'h3;
  localparam int GAP_CYCLES = 2;
  // t is the top 13 phase bits; triangle folds the lower 12 around the MSB
  function automatic logic [11:0] wave_sample(mode_t m, logic [12:0] t);
    return m == MODE_SAW    ? t[12:1] :
           m == MODE_SQUARE ? {12{t[12]}} :
           m == MODE_TRI    ? (t[12] ? ~t[11:0] : t[11:0]) : 12'h800;
  endfunction
endpackage

// File: rtl/spi_dac_tx.sv
// spi_dac_tx: SCK divider and 32-bit MSB-first shifter with chip select and done pulse
module spi_dac_tx
  import wavegen_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] data,
  output logic                  mosi,
  output logic                  sck,
  output logic                  cs,
  output logic                  tick,
  output logic                  done
);
  localparam int DW = $clog2(N + 1);
  localparam int HW = $clog2(2 * FRAME_BITS);
  logic [DW-1:0] div;
  logic [HW-1:0] hc;
  logic [FRAME_BITS-1:0] sr;
  logic tk;
  assign tk = !cs && div == DW'(N - 1);
  assign done = tk && sck && hc == HW'(2 * FRAME_BITS - 1);
  // mosi moves on the falling SCK edge so it is stable for a full period around each rise
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs <= 1'b1;
      sck <= 1'b0;
      mosi <= 1'b0;
      tick <= 1'b0;
      div <= '0;
      hc <= '0;
      sr <= '0;
    end else begin
      tick <= tk;
      if (start) begin
        cs <= 1'b0;
        sr <= data;
        mosi <= data[FRAME_BITS-1];
        div <= '0;
        hc <= '0;
      end else if (tk) begin
        div <= '0;
        hc <= hc + HW'(1);
        sck <= ~sck;
        if (sck) begin
          sr <= {sr[FRAME_BITS-2:0], 1'b0};
          mosi <= done ? 1'b0 : sr[FRAME_BITS-2];
          cs <= done;
        end
      end else if (!cs) begin
        div <= div + DW'(1);
      end
    end
  end
endmodule

// File: rtl/wavegen_dac.sv
// wavegen_dac: multi-channel phase-accumulator waveform generator driving an SPI DAC
// Define WAVEGEN_SAMPLE_OUT_EN to expose sample_out/chan_out/sample_vld.
module wavegen_dac
  import wavegen_pkg::*;
#(
  parameter int N = 3,
  parameter int CHANNELS = 4,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] step,
  output logic          spi_mosi,
  output logic          spi_sck,
  output logic          dac_cs,
  output logic          dac_clr,
  output logic          cs_test,
  output logic          clk_test
`ifdef WAVEGEN_SAMPLE_OUT_EN
  ,
  output logic [11:0]   sample_out,
  output logic [1:0]    chan_out,
  output logic          sample_vld
`endif
);
  localparam logic [PW-1:0] OFS = PW'((2 ** PW) / CHANNELS);
  state_t state;
  mode_t mode_q;
  logic [PW-1:0] acc, step_q;
  logic [1:0] ch, gcnt;
  logic [12:0] ph;
  logic [11:0] smp;
  logic [FRAME_BITS-1:0] word;
  logic done, last;
  assign ph = 13'((acc + OFS * PW'(ch)) >> (PW - 13));
  // channel 0 uses the live mode since it is latched on this same LOAD
  assign smp = wave_sample(ch == 2'd0 ? mode_t'(mode) : mode_q, ph);
  assign word = {8'h00, CMD_WRITE_UPDATE, 2'b00, ch, smp, 4'h0};
  assign last = ch == 2'(CHANNELS - 1);
  spi_dac_tx #(.N(N)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(state == LOAD),
    .data(word),
    .mosi(spi_mosi),
    .sck(spi_sck),
    .cs(dac_cs),
    .tick(clk_test),
    .done(done)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      step_q <= '0;
      mode_q <= MODE_SAW;
      ch <= '0;
      gcnt <= '0;
      cs_test <= 1'b0;
      dac_clr <= 1'b0;
    end else begin
      dac_clr <= 1'b1;
      cs_test <= 1'b0;
      case (state)
        IDLE: state <= en ? LOAD : IDLE;
        LOAD: begin
          state <= SHIFT;
          cs_test <= ch == 2'd0;
          if (ch == 2'd0) begin
            mode_q <= mode_t'(mode);
            step_q <= step;
          end
        end
        SHIFT: begin
          state <= done ? GAP : SHIFT;
          gcnt <= '0;
        end
        default: begin
          gcnt <= gcnt + 2'd1;
          if (gcnt == 2'(GAP_CYCLES - 1)) begin
            if (last) acc <= acc + step_q;
            ch <= (last || !en) ? 2'd0 : ch + 2'd1;
            state <= en ? LOAD : IDLE;
          end
        end
      endcase
    end
  end
`ifdef WAVEGEN_SAMPLE_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      sample_out <= '0;
      chan_out <= '0;
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= state == LOAD;
      if (state == LOAD) begin
        sample_out <= smp;
        chan_out <= ch;
      end
    end
  end
`endif
endmodule

// File: tb/tb_wavegen_dac.sv
// tb_wavegen_dac: scoreboard bench capturing SPI frames and checking them against queued words
module tb_wavegen_dac;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [15:0] step = 16'h0;
  logic spi_mosi, spi_sck, dac_cs, dac_clr, cs_test, clk_test;
  int checks = 0, passes = 0;
  int starts = 0, ends = 0, ncs = 0, cyc = 0, t_rise = -1000;
  int nbits = 0, lowlen = 0, tk = 0;
  logic p_cs = 1'b1, p_sck = 1'b0;
  logic [31:0] shr = '0;
  logic [31:0] q[$];

  wavegen_dac #(.N(3), .CHANNELS(2), .PW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .step(step),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck), .dac_cs(dac_cs),
    .dac_clr(dac_clr), .cs_test(cs_test), .clk_test(clk_test)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] w(input int c, input logic [11:0] s);
    return {8'h00, 4'h3, 4'(c), s, 4'h0};
  endfunction

  task automatic wait_starts(input int target);
    for (int i = 0; i < 8000 && starts < target; i++) @(negedge clk);
    chk("wait_starts", starts, target);
  endtask

  task automatic wait_ends(input int target);
    for (int i = 0; i < 8000 && ends < target; i++) @(negedge clk);
    chk("wait_ends", ends, target);
  endtask

  // monitor: reassemble frames from SCK rises, check framing and pop the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      nbits = 0;
      p_cs = 1'b1;
      p_sck = 1'b0;
    end else begin
      if (clk_test) tk++;
      if (!dac_cs) lowlen++;
      if (cs_test) ncs++;
      if (!dac_cs && p_cs) begin
        starts++;
        lowlen = 1;
        tk = 0;
        nbits = 0;
        if (cyc - t_rise < 50) chk("gap_cycles", cyc - t_rise, 3);
      end
      if (spi_sck && !p_sck && !dac_cs) begin
        shr = {shr[30:0], spi_mosi};
        nbits++;
      end
      if (dac_cs && !p_cs) begin
        ends++;
        t_rise = cyc;
        chk("cs_low_cycles", lowlen, 192);
        chk("sck_ticks", tk, 64);
        chk("frame_bits", nbits, 32);
        if (q.size() == 0) begin
          checks++;
          $display("FAIL frame_unexpected: got %h expected none", shr);
        end else chk("frame_word", shr, q.pop_front());
      end
      p_cs = dac_cs;
      p_sck = spi_sck;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs", dac_cs, 1);
    chk("rst_sck", spi_sck, 0);
    chk("rst_clr", dac_clr, 0);
    chk("rst_mosi", spi_mosi, 0);
    chk("rst_pulses", {cs_test, clk_test}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("clr_release", dac_clr, 1);
    // sawtooth, 17 sets; en drops during set 16 channel 0
    for (int s = 0; s <= 16; s++) begin
      q.push_back(w(0, 12'(s * 256)));
      if (s < 16) q.push_back(w(1, 12'(s * 256 + 2048)));
    end
    mode = 2'd0;
    step = 16'h1000;
    en = 1'b1;
    wait_starts(33);
    repeat (60) @(negedge clk);
    en = 1'b0;
    wait_ends(33);
    repeat (200) @(negedge clk);
    chk("idle_no_start", starts, 33);
    chk("cs_test_count_a", ncs, 17);
    chk("idle_cs", dac_cs, 1);
    chk("idle_sck", spi_sck, 0);
    // triangle then square switched mid-set, then reset mid-frame
    q.push_back(32'h0030_0000);
    q.push_back(32'h0031_FFF0);
    q.push_back(32'h0030_8000);
    q.push_back(32'h0031_7FF0);
    q.push_back(32'h0030_FFF0);
    q.push_back(32'h0031_0000);
    mode = 2'd2;
    step = 16'h4000;
    en = 1'b1;
    wait_starts(36);
    mode = 2'd1;
    wait_starts(40);
    repeat (60) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cs", dac_cs, 1);
    chk("abort_sck", spi_sck, 0);
    chk("abort_clr", dac_clr, 0);
    repeat (2) @(negedge clk);
    q.push_back(32'h0030_0000);
    q.push_back(32'h0031_8000);
    q.push_back(32'h0030_1000);
    mode = 2'd0;
    step = 16'h1000;
    rst = 1'b1;
    wait_starts(43);
    repeat (60) @(negedge clk);
    en = 1'b0;
    wait_ends(42);
    repeat (200) @(negedge clk);
    chk("final_starts", starts, 43);
    chk("cs_test_count", ncs, 23);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
